multicycle_controller: RTL and testbench

//  Moore FSM that sequences the shared ALU / data-memory / result-mux datapath as a multicycle MIPS core.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 142 ++++++++++++++
 tb/tb_multicycle_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs, ALU codes.
// No logic here; everything is a constant or a type.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode from ALUOp and Funct; purely combinational, zero latency.
// No handshake; unknown Funct or ALUOp falls back to add.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath; 3-5 cycles per instruction with mem_ready=1.
// Stalls in FETCH/MEMRD/MEMWR while mem_ready=0; write enables are gated low during reset.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     stateNext;
    logic [1:0] aluOp;
    logic       pcWrite;
    logic       branch;
    logic       memWriteRaw;
    logic       irWriteRaw;
    logic       regWriteRaw;
    logic       illegalRaw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext   = FETCH;
        aluOp       = ALUOP_ADD;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        pcWrite     = 1'b0;
        branch      = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        illegalRaw  = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB    = 2'b01;
                irWriteRaw = mem_ready;
                pcWrite    = mem_ready;
                stateNext  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_RTYPE:     stateNext = EXECUTE;
                    OP_BEQ:       stateNext = BRANCH;
                    OP_ADDI:      stateNext = ADDIEX;
                    OP_J:         stateNext = JUMP;
                    default: begin
                        stateNext  = FETCH;
                        illegalRaw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                stateNext = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD      = 1'b1;
                stateNext = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg    = 1'b1;
                regWriteRaw = 1'b1;
            end
            MEMWR: begin
                IorD        = 1'b1;
                memWriteRaw = 1'b1;
                stateNext   = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                ALUSrcA   = 1'b1;
                aluOp     = ALUOP_FUNCT;
                stateNext = ALUWB;
            end
            ALUWB: begin
                RegDst      = 1'b1;
                regWriteRaw = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                aluOp   = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                stateNext = ADDIWB;
            end
            ADDIWB: begin
                regWriteRaw = 1'b1;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                pcWrite = 1'b1;
            end
            default: stateNext = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (aluOp),
        .Funct      (Funct),
        .ALUControl (ALUControl)
    );

    // Reset must kill any in-flight write immediately, not at the next edge
    assign MemWrite   = memWriteRaw & rst_n;
    assign IRWrite    = irWriteRaw & rst_n;
    assign RegWrite   = regWriteRaw & rst_n;
    assign PCEn       = (pcWrite | (branch & Zero)) & rst_n;
    assign illegal_op = illegalRaw & rst_n;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its states.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, PCEn, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       illegal_op;
    logic [3:0] state_o;

    int nVec = 0;
    int nBad = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCEn       (PCEn),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and check the state entered
    task automatic cyc(input string tag, input int expState);
        @(posedge clk);
        #2;
        chk(tag, 32'(state_o), 32'(expState));
    endtask

    logic [5:0] fnTab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    logic [2:0] aluTab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

    initial begin
        rst_n = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("rst_state",    32'(state_o), 0);
        chk("rst_irwrite",  32'(IRWrite), 0);
        chk("rst_pcen",     32'(PCEn), 0);
        chk("rst_regwrite", 32'(RegWrite), 0);
        chk("rst_alusrcb",  32'(ALUSrcB), 1);
        cyc("rst_hold", 0);
        rst_n = 1'b1; Funct = 6'b100010;
        #1;
        chk("fetch_irwrite", 32'(IRWrite), 1);
        chk("fetch_pcen",    32'(PCEn), 1);

        // R-type sub: 0,1,6,7,0
        cyc("r_decode", 1);
        chk("r_dec_alusrcb", 32'(ALUSrcB), 3);
        chk("r_dec_regwrite", 32'(RegWrite), 0);
        cyc("r_exec", 6);
        chk("r_exec_aluctl", 32'(ALUControl), 32'(3'b110));
        chk("r_exec_regwrite", 32'(RegWrite), 0);
        cyc("r_aluwb", 7);
        chk("r_wb_regwrite", 32'(RegWrite), 1);
        chk("r_wb_regdst",   32'(RegDst), 1);
        cyc("r_done", 0);

        // Funct table through EXECUTE, including an unknown Funct
        for (int i = 0; i < 6; i++) begin
            Funct = fnTab[i];
            cyc("fn_decode", 1);
            cyc("fn_exec", 6);
            chk("fn_aluctl", 32'(ALUControl), 32'(aluTab[i]));
            cyc("fn_wb", 7);
            cyc("fn_done", 0);
        end

        // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4,0
        Op = 6'b100011;
        cyc("lw_decode", 1);
        cyc("lw_memadr", 2);
        chk("lw_adr_alusrcb", 32'(ALUSrcB), 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("lw_memrd", 3);
            if (i == 2) mem_ready = 1'b1;
            #1;
            chk("lw_memrd_iord", 32'(IorD), 1);
            chk("lw_memrd_regwrite", 32'(RegWrite), 0);
        end
        cyc("lw_memwb", 4);
        chk("lw_wb_memtoreg", 32'(MemtoReg), 1);
        chk("lw_wb_regwrite", 32'(RegWrite), 1);
        chk("lw_wb_regdst",   32'(RegDst), 0);
        cyc("lw_done", 0);

        // sw with three wait cycles in MEMWR
        Op = 6'b101011;
        cyc("sw_decode", 1);
        cyc("sw_memadr", 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc("sw_memwr", 5);
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk("sw_memwrite", 32'(MemWrite), 1);
            chk("sw_regwrite", 32'(RegWrite), 0);
        end
        cyc("sw_done", 0);

        // beq taken and not taken
        Op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            Zero = 1'(z);
            cyc("beq_decode", 1);
            cyc("beq_branch", 8);
            chk("beq_pcen",   32'(PCEn), 32'(z));
            chk("beq_pcsrc",  32'(PCSrc), 1);
            chk("beq_aluctl", 32'(ALUControl), 32'(3'b110));
            cyc("beq_done", 0);
        end
        Zero = 1'b0;

        // addi: 0,1,9,10,0
        Op = 6'b001000;
        cyc("addi_decode", 1);
        cyc("addi_ex", 9);
        chk("addi_alusrcb", 32'(ALUSrcB), 2);
        cyc("addi_wb", 10);
        chk("addi_regwrite", 32'(RegWrite), 1);
        chk("addi_regdst",   32'(RegDst), 0);
        cyc("addi_done", 0);

        // j: 0,1,11,0
        Op = 6'b000010;
        cyc("j_decode", 1);
        cyc("j_jump", 11);
        chk("j_pcen",  32'(PCEn), 1);
        chk("j_pcsrc", 32'(PCSrc), 2);
        cyc("j_done", 0);

        // Illegal opcode
        Op = 6'b111111;
        chk("ill_pre", 32'(illegal_op), 0);
        cyc("ill_decode", 1);
        chk("ill_pulse",    32'(illegal_op), 1);
        chk("ill_regwrite", 32'(RegWrite), 0);
        chk("ill_memwrite", 32'(MemWrite), 0);
        cyc("ill_back", 0);
        chk("ill_cleared", 32'(illegal_op), 0);

        // Reset asserted in the middle of a stalled store
        Op = 6'b101011;
        cyc("rsw_decode", 1);
        cyc("rsw_memadr", 2);
        mem_ready = 1'b0;
        cyc("rsw_memwr", 5);
        chk("rsw_memwrite_on", 32'(MemWrite), 1);
        rst_n = 1'b0;
        #1;
        chk("rsw_memwrite_off", 32'(MemWrite), 0);
        chk("rsw_state_rst",    32'(state_o), 0);
        cyc("rsw_hold", 0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rsw_release_state", 32'(state_o), 0);
        chk("rsw_release_irw",   32'(IRWrite), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
